// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with relative branch, absolute jump and
// call/return through a circular return-address stack.
module pc_sequencer #(
  parameter int AW = 8,
  parameter int RAS_DEPTH = 4,
  parameter logic [AW-1:0] RESET_ADDR = '0,
  localparam int DW = $clog2(RAS_DEPTH + 1),
  localparam int PW = $clog2(RAS_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic [2:0]    op,
  input  logic          cond,
  input  logic [AW-1:0] imm,
  input  logic          clr_err,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] depth,
  output logic          ovf,
  output logic          udf
);

  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_CALL   = 3'b011;
  localparam logic [2:0] OP_RET    = 3'b100;

  logic [AW-1:0] ras [RAS_DEPTH];
  logic [PW-1:0] tos;
  logic [AW-1:0] pc_inc;
  logic [PW-1:0] tos_inc;
  logic [PW-1:0] tos_dec;
  logic          ras_full;
  logic          ras_empty;

  always_comb begin
    pc_inc    = pc + AW'(1);
    tos_inc   = tos + PW'(1);
    tos_dec   = tos - PW'(1);
    ras_full  = (depth == DW'(RAS_DEPTH));
    ras_empty = (depth == '0);
  end

  // Error sets are written after the clear so a same-cycle event wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_ADDR;
      depth <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
      tos   <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= '0;
    end else begin
      if (clr_err) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end
      if (!stall) begin
        case (op)
          OP_BRANCH: pc <= cond ? (pc + imm) : pc_inc;
          OP_JUMP:   pc <= imm;
          OP_CALL: begin
            ras[tos_inc] <= pc_inc;
            tos          <= tos_inc;
            pc           <= imm;
            if (ras_full) ovf <= 1'b1;
            else          depth <= depth + DW'(1);
          end
          OP_RET: begin
            if (!ras_empty) begin
              pc    <= ras[tos];
              tos   <= tos_dec;
              depth <= depth - DW'(1);
            end else begin
              pc  <= pc_inc;
              udf <= 1'b1;
            end
          end
          default:   pc <= pc_inc;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (AW=8, RAS_DEPTH=4) with hand-computed
// expected values checked by immediate assertions.
module tb_pc_sequencer;

  localparam logic [2:0] NEXT = 3'b000;
  localparam logic [2:0] BRA  = 3'b001;
  localparam logic [2:0] JMP  = 3'b010;
  localparam logic [2:0] CALL = 3'b011;
  localparam logic [2:0] RET  = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stall = 1'b0;
  logic [2:0] op = NEXT;
  logic       cond = 1'b0;
  logic [7:0] imm = '0;
  logic       clr_err = 1'b0;
  logic [7:0] pc;
  logic [2:0] depth;
  logic       ovf;
  logic       udf;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(.AW(8), .RAS_DEPTH(4), .RESET_ADDR(8'h00)) dut (
    .clk(clk), .rst(rst), .stall(stall), .op(op), .cond(cond), .imm(imm),
    .clr_err(clr_err), .pc(pc), .depth(depth), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] o, input logic c, input logic [7:0] i,
                      input logic clr, input logic stl);
    op = o; cond = c; imm = i; clr_err = clr; stall = stl;
    @(posedge clk);
    #1;
    op = NEXT; cond = 1'b0; imm = '0; clr_err = 1'b0; stall = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_pc", pc, 8'h00);
    chk("rst_depth", depth, 3'd0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_udf", udf, 1'b0);

    step(NEXT, 0, 8'h00, 0, 0); chk("next1", pc, 8'h01);
    step(NEXT, 0, 8'h00, 0, 0); chk("next2", pc, 8'h02);
    step(NEXT, 0, 8'h00, 0, 0); chk("next3", pc, 8'h03);

    // asynchronous reset mid-cycle
    #3 rst = 1'b1;
    #1 chk("async_rst_pc", pc, 8'h00);
    #1 rst = 1'b0;

    step(JMP, 0, 8'h10, 0, 0); chk("jmp10", pc, 8'h10);
    step(BRA, 1, 8'hFE, 0, 0); chk("bra_taken_neg", pc, 8'h0E);
    step(BRA, 0, 8'hFE, 0, 0); chk("bra_not_taken", pc, 8'h0F);
    step(BRA, 1, 8'h05, 0, 0); chk("bra_taken_pos", pc, 8'h14);
    step(JMP, 0, 8'hFF, 0, 0); chk("jmpff", pc, 8'hFF);
    step(NEXT, 0, 8'h00, 0, 0); chk("wrap", pc, 8'h00);

    step(JMP, 0, 8'h20, 0, 0);
    step(CALL, 0, 8'h80, 0, 0); chk("call1_pc", pc, 8'h80); chk("call1_d", depth, 3'd1);
    step(CALL, 0, 8'hA0, 0, 0); chk("call2_pc", pc, 8'hA0); chk("call2_d", depth, 3'd2);
    step(RET, 0, 8'h00, 0, 0);  chk("ret1_pc", pc, 8'h81);  chk("ret1_d", depth, 3'd1);
    step(RET, 0, 8'h00, 0, 0);  chk("ret2_pc", pc, 8'h21);  chk("ret2_d", depth, 3'd0);
    chk("callret_ovf", ovf, 1'b0);

    // five calls into a four-entry stack: the return to 2 is lost
    step(JMP, 0, 8'h01, 0, 0);
    step(CALL, 0, 8'h02, 0, 0);
    step(CALL, 0, 8'h03, 0, 0);
    step(CALL, 0, 8'h04, 0, 0);
    step(CALL, 0, 8'h05, 0, 0); chk("call4_ovf", ovf, 1'b0); chk("call4_d", depth, 3'd4);
    step(CALL, 0, 8'h06, 0, 0); chk("call5_ovf", ovf, 1'b1); chk("call5_d", depth, 3'd4);
    chk("call5_pc", pc, 8'h06);
    step(RET, 0, 8'h00, 0, 0); chk("oret1", pc, 8'h06); chk("oret1_d", depth, 3'd3);
    step(RET, 0, 8'h00, 0, 0); chk("oret2", pc, 8'h05);
    step(RET, 0, 8'h00, 0, 0); chk("oret3", pc, 8'h04);
    step(RET, 0, 8'h00, 0, 0); chk("oret4", pc, 8'h03); chk("oret4_d", depth, 3'd0);
    chk("ovf_sticky", ovf, 1'b1);
    step(NEXT, 0, 8'h00, 1, 0); chk("ovf_clr", ovf, 1'b0); chk("ovf_clr_pc", pc, 8'h04);

    step(JMP, 0, 8'h40, 0, 0);
    step(RET, 0, 8'h00, 0, 0); chk("udf_pc", pc, 8'h41); chk("udf_set", udf, 1'b1);
    chk("udf_d", depth, 3'd0);
    step(NEXT, 0, 8'h00, 1, 0); chk("udf_clr", udf, 1'b0); chk("udf_clr_pc", pc, 8'h42);
    step(RET, 0, 8'h00, 1, 0);  chk("udf_set_wins", udf, 1'b1); chk("udf_sw_pc", pc, 8'h43);

    step(JMP, 0, 8'h55, 0, 1); chk("stall1_pc", pc, 8'h43);
    step(JMP, 0, 8'h55, 0, 1); chk("stall2_pc", pc, 8'h43);
    step(JMP, 0, 8'h55, 0, 1); chk("stall3_pc", pc, 8'h43);
    chk("stall_d", depth, 3'd0); chk("stall_udf", udf, 1'b1); chk("stall_ovf", ovf, 1'b0);
    step(CALL, 0, 8'h70, 1, 1); chk("stall_call_pc", pc, 8'h43);
    chk("stall_call_d", depth, 3'd0); chk("stall_clr_udf", udf, 1'b0);
    step(JMP, 0, 8'h55, 0, 0); chk("unstall_pc", pc, 8'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
